seq_stage_controller: RTL and testbench
=======================================

SEQ_STAGE_CONTROLLER -- requirements
Module: seq_stage_controller

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin execution from IDLE.
REQ-005 icode  input  4  instruction code from fetch stage, valid in DECODE through PCUPD.
REQ-006 imem_error  input  1  fetch address error, sampled in FETCH.
REQ-007 dmem_error  input  1  data memory address error, sampled in MEMORY.
REQ-008 mem_ready  input  1  data memory completion handshake.
REQ-009 fetch_en, decode_en, execute_en, wb_en, pc_en  output  1 each  one-cycle stage strobes.
REQ-010 mem_req  output  1  data memory request, held until mem_ready or dmem_error.
REQ-011 cc_en  output  1  condition-code (ZF/SF/OF) register write enable.
REQ-012 stat  output  2  status: AOK=0, HLT=1, ADR=2, INS=3.
REQ-013 busy  output  1  high in any state except IDLE and HALT.
REQ-014 instr_count  output  CNT_W  number of retired instructions.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; exactly one strobe is asserted per state, registered (no combinational input-to-strobe paths except mem_req hold).
REQ-016 IDLE -> FETCH on start=1; start is ignored in all other states.
REQ-017 FETCH: fetch_en=1; next DECODE, except imem_error=1 -> HALT with stat=ADR.
REQ-018 DECODE: decode_en=1; icode=0 (halt) -> HALT with stat=HLT; icode>4'hB -> HALT with stat=INS; otherwise -> EXECUTE.
REQ-019 EXECUTE: execute_en=1; cc_en=1 only when icode=4'h6 (OPq); next MEMORY if icode in {4,5,8,9,A,B}, else WRITEBACK.
REQ-020 MEMORY: mem_req=1; remains in MEMORY while mem_ready=0 and dmem_error=0; mem_ready=1 -> WRITEBACK; dmem_error=1 -> HALT with stat=ADR (dmem_error wins over simultaneous mem_ready).
REQ-021 WRITEBACK: wb_en=1; next PCUPD.
REQ-022 PCUPD: pc_en=1; instr_count increments by 1 (wraps modulo 2^CNT_W); next FETCH.
REQ-023 Latency: non-memory instruction = 5 cycles FETCH-to-PCUPD inclusive; memory instruction = 6 + N cycles, N = cycles mem_ready stays low.
REQ-024 HALT is sticky: all strobes 0, stat held, instr_count frozen, until reset.
REQ-025 Halting instructions (icode 0, invalid, faulted) do not increment instr_count and never assert wb_en, pc_en or cc_en.
REQ-026 Priority when several faults coincide: imem_error (ADR) > invalid/halt icode > dmem_error.

Reset
REQ-027 reset=1 at any edge, including mid-instruction or during MEMORY wait, forces state=IDLE, all strobes and mem_req=0, stat=AOK, busy=0, instr_count=0 on the next edge.
REQ-028 reset has priority over start and all fault inputs.

Structure
REQ-029 Shared package y86_pkg holds icode constants (IHALT..IPOPQ), stat encoding, and the state enum.
REQ-030 One sub-module, seq_icode_class: combinational icode -> {is_valid, is_halt, needs_mem, sets_cc}.

Verification
REQ-031 Reset, start, icode=6 (OPq), no faults -> strobes FETCH..PCUPD in 5 cycles, cc_en=1 in EXECUTE only, instr_count=1, stat=AOK.
REQ-032 icode=5 (mrmovq), mem_ready low 3 cycles -> mem_req high 4 cycles, total 9 cycles, cc_en never asserted, instr_count=1.
REQ-033 icode=0 -> HALT after DECODE, stat=1, busy=0, instr_count unchanged; further start pulses ignored.
REQ-034 icode=4'hC -> stat=3; imem_error=1 in FETCH with icode=4'hC -> stat=2.
REQ-035 icode=A, dmem_error and mem_ready both 1 in MEMORY -> HALT, stat=2, wb_en never asserted.
REQ-036 reset asserted during MEMORY wait of icode=B -> IDLE next cycle, mem_req=0, instr_count=0, stat=0; subsequent start runs normally.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86 stage controller:
// instruction codes, status encoding and controller state enum.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

endpackage

// File: rtl/seq_icode_class.sv
// Combinational instruction-code classifier.
// Ports: icode (in, 4) -> is_valid, is_halt, needs_mem, sets_cc (out, 1 each).
module seq_icode_class
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       is_valid,
  output logic       is_halt,
  output logic       needs_mem,
  output logic       sets_cc
);

  always_comb begin
    is_valid  = 1'b0;
    is_halt   = 1'b0;
    needs_mem = 1'b0;
    sets_cc   = 1'b0;
    case (icode)
      IHALT:   begin is_valid = 1'b1; is_halt = 1'b1; end
      INOP, IRRMOVQ, IIRMOVQ, IJXX:
               is_valid = 1'b1;
      IOPQ:    begin is_valid = 1'b1; sets_cc = 1'b1; end
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ:
               begin is_valid = 1'b1; needs_mem = 1'b1; end
      default: is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Sequential (non-pipelined) Y86 stage controller. Walks each instruction
// through FETCH..PCUPD, one registered strobe per stage, and halts stickily
// on halt/invalid instructions or memory address errors.
// Ports:
//   clk, reset (sync, active-high), start (begin from IDLE)
//   icode[3:0], imem_error, dmem_error, mem_ready  (inputs)
//   fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, cc_en (strobes)
//   stat[1:0], busy, instr_count[CNT_W-1:0]
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             mem_req,
  output logic             cc_en,
  output logic [1:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  logic   is_valid;
  logic   is_halt;
  logic   needs_mem;
  logic   sets_cc;

  seq_icode_class u_icode_class (
    .icode     (icode),
    .is_valid  (is_valid),
    .is_halt   (is_halt),
    .needs_mem (needs_mem),
    .sets_cc   (sets_cc)
  );

  // Strobes are loaded for the state being entered, so each one is high
  // exactly while the controller sits in its stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      execute_en  <= 1'b0;
      mem_req     <= 1'b0;
      wb_en       <= 1'b0;
      pc_en       <= 1'b0;
      cc_en       <= 1'b0;
      busy        <= 1'b0;
      stat        <= STAT_AOK;
      instr_count <= '0;
    end else begin
      fetch_en   <= 1'b0;
      decode_en  <= 1'b0;
      execute_en <= 1'b0;
      mem_req    <= 1'b0;
      wb_en      <= 1'b0;
      pc_en      <= 1'b0;
      cc_en      <= 1'b0;
      busy       <= 1'b1;
      case (state)
        S_IDLE: begin
          busy <= start;
          if (start) begin
            state    <= S_FETCH;
            fetch_en <= 1'b1;
          end
        end
        S_FETCH: begin
          // Fetch address fault outranks anything decode would find.
          if (imem_error) begin
            state <= S_HALT;
            stat  <= STAT_ADR;
            busy  <= 1'b0;
          end else begin
            state     <= S_DECODE;
            decode_en <= 1'b1;
          end
        end
        S_DECODE: begin
          if (is_halt) begin
            state <= S_HALT;
            stat  <= STAT_HLT;
            busy  <= 1'b0;
          end else if (!is_valid) begin
            state <= S_HALT;
            stat  <= STAT_INS;
            busy  <= 1'b0;
          end else begin
            state      <= S_EXECUTE;
            execute_en <= 1'b1;
            cc_en      <= sets_cc;
          end
        end
        S_EXECUTE: begin
          if (needs_mem) begin
            state   <= S_MEMORY;
            mem_req <= 1'b1;
          end else begin
            state <= S_WRITEBACK;
            wb_en <= 1'b1;
          end
        end
        S_MEMORY: begin
          // dmem_error wins over a simultaneous mem_ready.
          if (dmem_error) begin
            state <= S_HALT;
            stat  <= STAT_ADR;
            busy  <= 1'b0;
          end else if (mem_ready) begin
            state <= S_WRITEBACK;
            wb_en <= 1'b1;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          state <= S_PCUPD;
          pc_en <= 1'b1;
        end
        S_PCUPD: begin
          state       <= S_FETCH;
          fetch_en    <= 1'b1;
          instr_count <= instr_count + CNT_W'(1);
        end
        S_HALT: begin
          busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller: table of single-instruction
// vectors plus hand-written reset-in-MEMORY and back-to-back sequences.
module tb_seq_stage_controller;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       icode;
  logic             imem_error;
  logic             dmem_error;
  logic             mem_ready;
  logic             fetch_en, decode_en, execute_en, wb_en, pc_en, mem_req, cc_en;
  logic [1:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  seq_stage_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .icode       (icode),
    .imem_error  (imem_error),
    .dmem_error  (dmem_error),
    .mem_ready   (mem_ready),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .execute_en  (execute_en),
    .wb_en       (wb_en),
    .pc_en       (pc_en),
    .mem_req     (mem_req),
    .cc_en       (cc_en),
    .stat        (stat),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ic;
    int         wt;    // MEMORY cycles with mem_ready low before it rises
    logic       ie;    // imem_error during FETCH
    logic       de;    // dmem_error during MEMORY
    int         cyc;   // cycles with a strobe high
    int         cc;
    int         wb;
    int         mr;
    logic       halt;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_strobes", longint'({fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en, cc_en}), 0);
    check("reset_stat", longint'(stat), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_count", longint'(instr_count), 0);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH; returns sampling PCUPD or HALT.
  task automatic run_instr(input logic [3:0] ic, input int wt, input logic ie, input logic de,
                           output int cyc, output int cc, output int wb, output int mr,
                           output logic halted);
    int mc;
    mc = 0; cyc = 0; cc = 0; wb = 0; mr = 0; halted = 1'b0;
    icode = ic;
    for (int t = 0; t < 100; t++) begin
      if (!busy) begin
        halted = 1'b1;
        imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
        return;
      end
      check("onehot", longint'($countones({fetch_en, decode_en, execute_en, mem_req, wb_en, pc_en})), 1);
      cyc++;
      cc += int'(cc_en);
      wb += int'(wb_en);
      mr += int'(mem_req);
      if (mem_req) mc++;
      imem_error = ie & fetch_en;
      dmem_error = de & mem_req;
      mem_ready  = mem_req && (mc > wt);
      if (pc_en) return;
      @(negedge clk);
    end
    check("timeout", 1, 0);
  endtask

  initial begin
    int cyc, cc, wb, mr;
    logic halted;

    vecs[0]  = '{4'h6, 0, 1'b0, 1'b0, 5, 1, 1, 0, 1'b0, 2'd0};
    vecs[1]  = '{4'h5, 3, 1'b0, 1'b0, 9, 0, 1, 4, 1'b0, 2'd0};
    vecs[2]  = '{4'h1, 0, 1'b0, 1'b0, 5, 0, 1, 0, 1'b0, 2'd0};
    vecs[3]  = '{4'h0, 0, 1'b0, 1'b0, 2, 0, 0, 0, 1'b1, 2'd1};
    vecs[4]  = '{4'hC, 0, 1'b0, 1'b0, 2, 0, 0, 0, 1'b1, 2'd3};
    vecs[5]  = '{4'hC, 0, 1'b1, 1'b0, 1, 0, 0, 0, 1'b1, 2'd2};
    vecs[6]  = '{4'hA, 0, 1'b0, 1'b1, 4, 0, 0, 1, 1'b1, 2'd2};
    vecs[7]  = '{4'hB, 0, 1'b0, 1'b0, 6, 0, 1, 1, 1'b0, 2'd0};
    vecs[8]  = '{4'hF, 0, 1'b0, 1'b0, 2, 0, 0, 0, 1'b1, 2'd3};
    vecs[9]  = '{4'h8, 2, 1'b0, 1'b1, 4, 0, 0, 1, 1'b1, 2'd2};
    vecs[10] = '{4'h6, 0, 1'b1, 1'b0, 1, 0, 0, 0, 1'b1, 2'd2};
    vecs[11] = '{4'h9, 1, 1'b0, 1'b0, 7, 0, 1, 2, 1'b0, 2'd0};

    icode = 4'h0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      pulse_start();
      run_instr(vecs[i].ic, vecs[i].wt, vecs[i].ie, vecs[i].de, cyc, cc, wb, mr, halted);
      check($sformatf("v%0d_cycles", i), longint'(cyc), longint'(vecs[i].cyc));
      check($sformatf("v%0d_cc", i), longint'(cc), longint'(vecs[i].cc));
      check($sformatf("v%0d_wb", i), longint'(wb), longint'(vecs[i].wb));
      check($sformatf("v%0d_memreq", i), longint'(mr), longint'(vecs[i].mr));
      check($sformatf("v%0d_halted", i), longint'(halted), longint'(vecs[i].halt));
      check($sformatf("v%0d_stat", i), longint'(stat), longint'(vecs[i].st));
      if (vecs[i].halt) begin
        check($sformatf("v%0d_count", i), longint'(instr_count), 0);
        pulse_start();
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_sticky", i), longint'({busy, fetch_en, decode_en, pc_en}), 0);
        check($sformatf("v%0d_stat_held", i), longint'(stat), longint'(vecs[i].st));
        check($sformatf("v%0d_count_frozen", i), longint'(instr_count), 0);
      end else begin
        @(negedge clk);
        check($sformatf("v%0d_count", i), longint'(instr_count), 1);
        check($sformatf("v%0d_refetch", i), longint'(fetch_en), 1);
      end
    end

    // Reset during MEMORY wait of icode B, after one retired instruction.
    do_reset();
    pulse_start();
    run_instr(4'h6, 0, 1'b0, 1'b0, cyc, cc, wb, mr, halted);
    icode = 4'hB;
    for (int t = 0; t < 20 && !mem_req; t++) @(negedge clk);
    check("seqA_in_memory", longint'(mem_req), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("seqA_wait_hold", longint'({mem_req, busy}), 3);
    check("seqA_count_before", longint'(instr_count), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("seqA_mem_req", longint'(mem_req), 0);
    check("seqA_busy", longint'(busy), 0);
    check("seqA_count", longint'(instr_count), 0);
    check("seqA_stat", longint'(stat), 0);
    pulse_start();
    run_instr(4'hB, 1, 1'b0, 1'b0, cyc, cc, wb, mr, halted);
    check("seqA_rerun_cycles", longint'(cyc), 7);
    check("seqA_rerun_memreq", longint'(mr), 2);
    @(negedge clk);
    check("seqA_rerun_count", longint'(instr_count), 1);

    // Back-to-back: two retired instructions, then a halt keeps count at 2.
    do_reset();
    pulse_start();
    run_instr(4'h2, 0, 1'b0, 1'b0, cyc, cc, wb, mr, halted);
    @(negedge clk);
    run_instr(4'h4, 2, 1'b0, 1'b0, cyc, cc, wb, mr, halted);
    check("seqB_second_cycles", longint'(cyc), 8);
    @(negedge clk);
    check("seqB_count2", longint'(instr_count), 2);
    run_instr(4'h0, 0, 1'b0, 1'b0, cyc, cc, wb, mr, halted);
    check("seqB_halted", longint'(halted), 1);
    check("seqB_stat", longint'(stat), 1);
    check("seqB_count_kept", longint'(instr_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
